// File: rtl/rtn_addr_stack_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rtn_addr_stack_pkg                                    |
// | Purpose  : Shared CPU address constants and return-stack         |
// |            operation decode used by the PC, control unit and     |
// |            the return-address stack.                             |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package rtn_addr_stack_pkg;

    // Width of a program address; the PC and the return stack agree on it.
    localparam int PC_ADDR_W = 8;

    // Program counter value after reset.
    localparam logic [PC_ADDR_W-1:0] RST_PC = 8'h00;

    // One stack operation per cycle, resolved from push/pop and occupancy.
    typedef enum logic [2:0] {
        OP_IDLE       = 3'd0,  // nothing requested
        OP_PUSH       = 3'd1,  // push into a non-full stack
        OP_PUSH_FULL  = 3'd2,  // push refused, stack full
        OP_POP        = 3'd3,  // pop leaving at least one entry
        OP_POP_LAST   = 3'd4,  // pop of the only entry
        OP_POP_EMPTY  = 3'd5,  // pop refused, stack empty
        OP_REPLACE    = 3'd6,  // push+pop on a non-empty stack: overwrite top
        OP_PUSH_EMPTY = 3'd7   // push+pop on an empty stack: acts as a push
    } stk_op_e;

    // Classify the requested operation against the current occupancy.
    function automatic stk_op_e decode_op(
        input logic push,
        input logic pop,
        input logic empty,
        input logic full,
        input logic last
    );
        stk_op_e op;
        op = OP_IDLE;
        if (push && pop) begin
            op = empty ? OP_PUSH_EMPTY : OP_REPLACE;
        end else if (push) begin
            op = full ? OP_PUSH_FULL : OP_PUSH;
        end else if (pop) begin
            if (empty) begin
                op = OP_POP_EMPTY;
            end else if (last) begin
                op = OP_POP_LAST;
            end else begin
                op = OP_POP;
            end
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtn_stk_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rtn_stk_ram                                           |
// | Purpose  : DEPTH x ADDR_W register array for the return stack,   |
// |            synchronous write, asynchronous read. Not reset.      |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module rtn_stk_ram #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [ADDR_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [ADDR_W-1:0] o_rdata
);

    logic [ADDR_W-1:0] r_mem [DEPTH];

    // Write one entry on the rising edge; contents carry no reset value.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/rtn_addr_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rtn_addr_stack                                        |
// | Purpose  : Hardware return-address (call) stack. CALL pushes the |
// |            return address, RET pops it; the registered top copy  |
// |            feeds the PC with zero latency. Sticky over/underflow.|
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module rtn_addr_stack
    import rtn_addr_stack_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4,
    parameter int ADDR_W = PC_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic              i_clr_err,
    output logic [ADDR_W-1:0] o_return_addr,
    output logic [CNT_W-1:0]  o_depth,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_TWO       = CNT_W'(2);

    // Architectural state
    logic [CNT_W-1:0]  r_depth;
    logic [ADDR_W-1:0] r_top;
    logic              r_ovf;
    logic              r_und;

    // Decode and next-state
    logic              w_empty;
    logic              w_full;
    logic              w_last;
    stk_op_e           w_op;
    logic [CNT_W-1:0]  w_depth_m1;
    logic [CNT_W-1:0]  w_depth_m2;
    logic [CNT_W-1:0]  w_depth_nxt;
    logic [ADDR_W-1:0] w_top_nxt;
    logic              w_ovf_set;
    logic              w_und_set;

    // Storage interface
    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [IDX_W-1:0]  w_raddr;
    logic [ADDR_W-1:0] w_rdata;

    assign w_empty    = (r_depth == '0);
    assign w_full     = (r_depth == c_DEPTH_CNT);
    assign w_last     = (r_depth == c_ONE);
    assign w_depth_m1 = r_depth - c_ONE;
    assign w_depth_m2 = r_depth - c_TWO;
    assign w_op       = decode_op(i_push, i_pop, w_empty, w_full, w_last);

    // Entry just below the current top becomes the new top on a pop.
    assign w_raddr = w_depth_m2[IDX_W-1:0];

    rtn_stk_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (i_push_addr),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Resolve the cycle's operation into pointer, top, write and error updates.
    always_comb begin
        w_depth_nxt = r_depth;
        w_top_nxt   = r_top;
        w_we        = 1'b0;
        w_waddr     = r_depth[IDX_W-1:0];
        w_ovf_set   = 1'b0;
        w_und_set   = 1'b0;
        case (w_op)
            OP_PUSH: begin
                w_we        = 1'b1;
                w_waddr     = r_depth[IDX_W-1:0];
                w_depth_nxt = r_depth + c_ONE;
                w_top_nxt   = i_push_addr;
            end
            OP_PUSH_FULL: begin
                w_ovf_set = 1'b1;
            end
            OP_POP: begin
                w_depth_nxt = w_depth_m1;
                w_top_nxt   = w_rdata;
            end
            OP_POP_LAST: begin
                w_depth_nxt = '0;
                w_top_nxt   = '0;
            end
            OP_POP_EMPTY: begin
                w_und_set = 1'b1;
            end
            OP_REPLACE: begin
                // Return and re-call in one cycle: overwrite the top in place.
                w_we      = 1'b1;
                w_waddr   = w_depth_m1[IDX_W-1:0];
                w_top_nxt = i_push_addr;
            end
            OP_PUSH_EMPTY: begin
                // The pop half has nothing to take, so it still counts as underflow.
                w_we        = 1'b1;
                w_waddr     = '0;
                w_depth_nxt = c_ONE;
                w_top_nxt   = i_push_addr;
                w_und_set   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State register; a new error event in the clearing cycle wins over clr_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_depth <= '0;
            r_top   <= '0;
            r_ovf   <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_depth <= w_depth_nxt;
            r_top   <= w_top_nxt;
            r_ovf   <= (r_ovf & ~i_clr_err) | w_ovf_set;
            r_und   <= (r_und & ~i_clr_err) | w_und_set;
        end
    end

    assign o_return_addr = r_top;
    assign o_depth       = r_depth;
    assign o_empty       = w_empty;
    assign o_full        = w_full;
    assign o_overflow    = r_ovf;
    assign o_underflow   = r_und;

endmodule
`default_nettype wire
